// File: rtl/pwm_bank.sv
// pwm_bank: bank of PWM channels sharing one prescaler and period counter.
// Ports: clk, rst_n (sync, active-low); out_en/pwm_en per-channel enables;
//   presc (step = presc+1 clocks); mode (0 edge, 1 center);
//   duty_wr/duty_ch/duty_data write a channel's pending duty;
//   out registered channel outputs; period_start pulses after each boundary.
module pwm_bank #(
    parameter int NUM_CH  = 16,
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  out_en,
    input  logic [NUM_CH-1:0]  pwm_en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               mode,
    input  logic               duty_wr,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [DUTY_W-1:0]  duty_data,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);
    localparam logic [CH_W:0]     CH_LIM   = NUM_CH[CH_W:0];

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic [DUTY_W-1:0]  cnt;
    logic [DUTY_W-1:0]  cnt_nxt;
    logic               dir_up;
    logic               dir_nxt;
    logic               mode_q;
    logic               wrap;
    logic               wr_ok;
    logic [NUM_CH-1:0]  pwm_lvl;
    logic [DUTY_W-1:0]  pend [NUM_CH];
    logic [DUTY_W-1:0]  act  [NUM_CH];

    // Compared against the live presc so a change acts on the next clock;
    // a smaller value simply ends the current step early.
    assign tick  = (presc_cnt >= presc);
    assign wr_ok = duty_wr && ({1'b0, duty_ch} < CH_LIM);

    // Counter stepping. wrap marks the tick on which cnt becomes 0.
    // Center mode visits MAX and 0 once each per period.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_up;
        wrap    = 1'b0;
        if (tick) begin
            if (!mode_q) begin
                cnt_nxt = cnt + 1'b1;
                wrap    = (cnt == DUTY_MAX);
            end else if (dir_up) begin
                if (cnt == DUTY_MAX) begin
                    cnt_nxt = cnt - 1'b1;
                    dir_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
                wrap    = (cnt == DUTY_ONE);
            end
        end
    end

    // Full-scale duty forces a constant high so there is no gap at wrap.
    always_comb begin
        pwm_lvl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_lvl[i] = (act[i] == DUTY_MAX) || (cnt < act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_up       <= 1'b1;
            mode_q       <= mode;
            period_start <= 1'b0;
            out          <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            cnt          <= cnt_nxt;
            dir_up       <= wrap ? 1'b1 : dir_nxt;
            period_start <= wrap;
            out          <= out_en & (~pwm_en | pwm_lvl);
            if (wrap) begin
                mode_q <= mode;
            end
            // Active copies the pre-write pending value on a coinciding write.
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) begin
                    act[i] <= pend[i];
                end
            end
            if (wr_ok) begin
                pend[duty_ch] <= duty_data;
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed and randomized checks of pwm_bank against a
// period-position reference model plus literal expectations.
module tb_pwm_bank;

    localparam int NCH  = 16;
    localparam int MAXV = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] out_en;
    logic [NCH-1:0] pwm_en;
    logic [7:0]     presc;
    logic           mode;
    logic           duty_wr;
    logic [3:0]     duty_ch;
    logic [7:0]     duty_data;
    logic [NCH-1:0] out;
    logic           period_start;

    pwm_bank #(.NUM_CH(NCH), .DUTY_W(8), .PRESC_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .out_en       (out_en),
        .pwm_en       (pwm_en),
        .presc        (presc),
        .mode         (mode),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_data    (duty_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;
    int hi [NCH];
    int per_n;

    // Reference model: position within the period in ticks; cnt derived
    // arithmetically from it (triangle for center mode).
    int             m_sub, m_pos, m_c;
    bit             m_ctr, m_bnd;
    logic [7:0]     m_pend [NCH];
    logic [7:0]     m_act  [NCH];
    logic [NCH-1:0] m_out;
    logic           m_ps;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sub = 0;
            m_pos = 0;
            m_ctr = mode;
            m_out = '0;
            m_ps  = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 8'h00;
                m_act[i]  = 8'h00;
            end
        end else begin
            m_c = (!m_ctr || m_pos <= MAXV) ? m_pos : 2 * MAXV - m_pos;
            for (int i = 0; i < NCH; i++) begin
                m_out[i] = out_en[i] && (!pwm_en[i] || m_act[i] == 8'hFF
                                         || m_c < int'(m_act[i]));
            end
            m_bnd = 0;
            if (m_sub >= int'(presc)) begin
                m_sub = 0;
                m_pos++;
                if (m_pos == (m_ctr ? 2 * MAXV : MAXV + 1)) begin
                    m_pos = 0;
                    m_bnd = 1;
                end
            end else begin
                m_sub++;
            end
            m_ps = m_bnd;
            if (m_bnd) begin
                m_act = m_pend;
                m_ctr = mode;
            end
            if (duty_wr && int'(duty_ch) < NCH) begin
                m_pend[duty_ch] = duty_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (out !== m_out) begin
                errors++;
                $display("FAIL model_out t=%0t: got %h want %h", $time, out, m_out);
            end
            checks++;
            if (period_start !== m_ps) begin
                errors++;
                $display("FAIL model_ps t=%0t: got %b want %b",
                         $time, period_start, m_ps);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic wr(input int ch, input int d);
        duty_wr   = 1'b1;
        duty_ch   = 4'(ch);
        duty_data = 8'(d);
        @(negedge clk);
        duty_wr = 1'b0;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 5000);
        if (!period_start) begin
            errors++;
            $display("FAIL wait_ps: timeout after %0d clocks", n);
        end
    endtask

    // Starts on a period_start cycle, ends on the next one.
    task automatic measure();
        per_n = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        do begin
            per_n++;
            for (int i = 0; i < NCH; i++) if (out[i]) hi[i]++;
            @(negedge clk);
        end while (!period_start && per_n < 5000);
        if (!period_start) begin
            errors++;
            $display("FAIL measure: timeout after %0d clocks", per_n);
        end
    endtask

    initial begin
        int n;
        int r;
        rst_n     = 1'b0;
        out_en    = '1;
        pwm_en    = '1;
        presc     = 8'd0;
        mode      = 1'b0;
        duty_wr   = 1'b1;
        duty_ch   = 4'd3;
        duty_data = 8'h55;
        @(negedge clk);
        chk_on = 1;
        @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_ps", int'(period_start), 0);
        rst_n   = 1'b1;
        duty_wr = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_out", int'(out), 0);
        wait_ps(n);
        chk("first_ps_delay", n + 20, 256);
        repeat (3) @(negedge clk);
        chk("post_bnd_out", int'(out), 0);

        out_en = 16'h002F;
        pwm_en = 16'h003B;
        wr(0, 8'h00);
        wr(1, 8'hFF);
        wr(3, 8'h80);
        wr(5, 8'h80);
        wait_ps(n);
        measure();
        measure();
        chk("edge_period", per_n, 256);
        chk("ch3_high", hi[3], 128);
        chk("ch0_duty0", hi[0], 0);
        chk("ch1_full", hi[1], 256);
        chk("ch2_nopwm", hi[2], 256);
        chk("ch4_noen", hi[4], 0);
        chk("ch9_idle", hi[9], 0);

        fork
            measure();
            begin
                repeat (16) @(negedge clk);
                wr(5, 8'h40);
            end
        join
        chk("ch5_cur", hi[5], 128);
        fork
            measure();
            begin
                repeat (255) @(negedge clk);
                duty_wr   = 1'b1;
                duty_ch   = 4'd5;
                duty_data = 8'h20;
                @(negedge clk);
                duty_wr = 1'b0;
            end
        join
        chk("ch5_next", hi[5], 64);
        measure();
        chk("ch5_bnd_wr", hi[5], 64);
        measure();
        chk("ch5_late", hi[5], 32);

        mode   = 1'b1;
        presc  = 8'd1;
        out_en = out_en | 16'h0040;
        pwm_en = pwm_en | 16'h0040;
        wr(6, 8'h40);
        wait_ps(n);
        measure();
        chk("ctr_period1", per_n, 1020);
        chk("ctr_ps_out6", int'(out[6]), 1);
        measure();
        chk("ctr_period2", per_n, 1020);
        chk("ctr_ch6", hi[6], 254);
        chk("ctr_ch3", hi[3], 510);

        mode   = 1'b0;
        out_en = out_en | 16'h8000;
        pwm_en = pwm_en | 16'h8000;
        wr(15, 8'h22);
        wait_ps(n);
        presc = 8'd0;
        measure();
        measure();
        chk("ch15_high", hi[15], 34);
        chk("ch14_idle", hi[14], 0);
        chk("ch3_kept", hi[3], 128);
        fork
            measure();
            begin
                repeat (100) @(negedge clk);
                presc = 8'd3;
            end
        join
        chk("presc_mid", per_n, 724);
        measure();
        chk("presc3_period", per_n, 1024);

        for (int k = 0; k < 15000; k++) begin
            duty_wr = ($urandom_range(0, 7) == 0);
            duty_ch = 4'($urandom);
            r = $urandom_range(0, 3);
            duty_data = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 149) == 0) out_en = 16'($urandom);
            if ($urandom_range(0, 149) == 0) pwm_en = 16'($urandom);
            if ($urandom_range(0, 799) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) mode = ~mode;
            rst_n = ($urandom_range(0, 2999) != 0);
            @(negedge clk);
        end
        rst_n   = 1'b1;
        duty_wr = 1'b0;
        repeat (4) @(negedge clk);
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, giving the number of PWM channels (1..32).
REQ-002 SHALL have parameter DUTY_W, default 8, giving the duty and period-counter width in bits (4..12).
REQ-003 SHALL have parameter PRESC_W, default 8, giving the prescaler width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port out_en, input, NUM_CH bits: per-channel output enable.
REQ-007 SHALL have port pwm_en, input, NUM_CH bits: per-channel PWM enable.
REQ-008 SHALL have port presc, input, PRESC_W bits: each counter step lasts presc+1 clocks.
REQ-009 SHALL have port mode, input, 1 bit: 0 selects edge-aligned mode; 1 selects center-aligned mode.
REQ-010 SHALL have port duty_wr, input, 1 bit: one-clock duty write strobe.
REQ-011 SHALL have port duty_ch, input, $clog2(NUM_CH) bits (minimum 1): the channel index for the write.
REQ-012 SHALL have port duty_data, input, DUTY_W bits: the duty value for the write.
REQ-013 SHALL have port out, output, NUM_CH bits: registered channel outputs.
REQ-014 SHALL have port period_start, output, 1 bit: one-clock pulse at each period boundary.

Function
REQ-015 SHALL keep a prescaler counter that increments each clock and produces a tick and clears to 0 when its value is >= presc; presc=0 SHALL produce a tick every clock.
REQ-016 SHALL apply a change of presc on the next clock, with no glitch beyond one shortened or lengthened step.
REQ-017 Edge mode: on each tick, the DUTY_W-bit counter cnt SHALL increment and wrap from 2^DUTY_W-1 to 0, giving a period of 2^DUTY_W*(presc+1) clocks.
REQ-018 Center mode: on each tick, cnt SHALL count up from 0 to 2^DUTY_W-1, then down to 0, with a single dwell at each end, giving a period of (2^(DUTY_W+1)-2)*(presc+1) clocks.
REQ-019 SHALL define the period boundary as the tick on which cnt becomes 0.
REQ-020 SHALL sample mode only at the period boundary; a mid-period mode change SHALL take effect from the next period.
REQ-021 On entering center mode, the counting direction SHALL be up.
REQ-022 SHALL hold a pending duty register and an active duty register per channel.
REQ-023 A duty_wr with duty_ch < NUM_CH SHALL load duty_data into that channel's pending register.
REQ-024 A duty_wr with duty_ch >= NUM_CH SHALL be ignored.
REQ-025 At the period boundary, every active register SHALL load from its pending register.
REQ-026 If duty_wr coincides with the boundary, the active register SHALL take the pre-write pending value, and the new value SHALL apply one period later.
REQ-027 period_start SHALL be high for exactly the one clock following the boundary tick, in both modes.
REQ-028 Per channel, out SHALL be 0 when out_en=0, regardless of pwm_en.
REQ-029 Per channel, out SHALL be 1 when out_en=1 and pwm_en=0.
REQ-030 Per channel with out_en=1 and pwm_en=1, out SHALL be 0 when duty=0.
REQ-031 Per channel with out_en=1 and pwm_en=1, out SHALL be 1 when duty=2^DUTY_W-1 (100 %, no gap at wrap).
REQ-032 Per channel with out_en=1 and pwm_en=1 and any other duty, out SHALL equal (cnt < duty).
REQ-033 out SHALL be registered with a latency of one clock from the cnt, active-duty and enable values it reflects.
REQ-034 Changes to out_en and pwm_en SHALL take effect with the same one-clock latency, not deferred to the period boundary.

Reset
REQ-035 While rst_n=0 at a clock edge, the prescaler, cnt, and all pending and active duty registers SHALL clear to 0, the direction SHALL be set to up, and out and period_start SHALL be 0.
REQ-036 duty_wr asserted during reset SHALL be ignored.
REQ-037 Releasing reset mid-period SHALL restart counting from cnt=0.
REQ-038 After reset, the first period_start SHALL occur one full period after release.

Verification (NUM_CH=16, DUTY_W=8, PRESC_W=8)
REQ-039 SHALL test: rst_n=0 for 2 clocks with duty_wr=1, out_en=pwm_en=0xFFFF -> out=0 and period_start=0; after release, duty reads as 0 so all outputs stay 0.
REQ-040 SHALL test: presc=0, mode=0, ch3 enabled, duty 0x80 written -> from the 2nd period, out[3] is high 128 of 256 clocks, period_start pulses every 256 clocks, and other channels stay 0.
REQ-041 SHALL test: ch0 duty 0x00 -> out[0] constant 0; ch1 duty 0xFF -> out[1] constant 1 across the wrap; ch2 out_en=1, pwm_en=0 -> out[2] constant 1; ch4 out_en=0, pwm_en=1 -> out[4] 0.
REQ-042 SHALL test: ch5 active duty 0x80, write 0x40 at cnt=0x10 -> the current period keeps 128 high clocks and the next has 64; a write exactly at the boundary clock applies one period later.
REQ-043 SHALL test: presc=1, mode=1, duty 0x40 -> period 1020 clocks, out high 254 clocks centered on cnt=0, and period_start every 1020 clocks.
REQ-044 SHALL test: duty_wr with duty_ch=0xF/data 0x22 then duty_ch=0x14 (truncated port, where applicable) -> only ch15 changes; presc changed 0->3 mid-period -> steps lengthen to 4 clocks within one step.
